// File: rtl/td4_prog_loader.sv
// TD4 program loader: fills the 16x8 program image from a framed byte stream and
// holds the core in reset while loading. Define LOADER_CSUM_EN to add a trailing checksum byte.
module td4_prog_loader #(
    parameter logic [7:0]   SYNC_BYTE   = 8'hA5,
    parameter int           HOLD_CYCLES = 4,
    parameter int           TIMEOUT_CYC = 1023,
    parameter logic [127:0] RESET_IMAGE = 128'h0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_in_valid,
    input  logic [7:0]   i_in_data,
    output logic         o_in_ready,
    output logic [127:0] o_mem_bus,
    output logic         o_cpu_rst_n,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err,
    output logic [3:0]   o_byte_cnt
);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int GAP_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
`ifdef LOADER_CSUM_EN
        S_CSUM   = 3'd2,
`endif
        S_COMMIT = 3'd3,
        S_ABORT  = 3'd4,
        S_HOLD   = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [GAP_W-1:0]  r_gap;
    logic [3:0]        r_byte_cnt;
    logic [127:0]      r_mem_bus;
    logic [15:0][7:0]  r_stage;
    logic              w_in_frame;
    logic              w_accept;
    logic              w_timeout;
`ifdef LOADER_CSUM_EN
    logic [7:0]        r_sum;
    logic [7:0]        w_csum_total;

    assign w_in_frame   = (r_state == S_LOAD) || (r_state == S_CSUM);
    assign w_csum_total = r_sum + i_in_data;
`else
    assign w_in_frame   = (r_state == S_LOAD);
`endif

    assign w_accept  = i_in_valid && (w_in_frame || (r_state == S_IDLE));
    // The gap counter sits one below the limit on the cycle that would make it reach TIMEOUT_CYC.
    assign w_timeout = (TIMEOUT_CYC != 0) && w_in_frame && !w_accept &&
                       (r_gap == GAP_W'(TIMEOUT_CYC - 1));

    assign o_mem_bus  = r_mem_bus;
    assign o_byte_cnt = r_byte_cnt;

    always_comb begin
        w_state_nxt = r_state;
        o_in_ready  = 1'b0;
        o_cpu_rst_n = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_in_ready  = 1'b1;
                o_cpu_rst_n = 1'b1;
                if (w_accept && (i_in_data == SYNC_BYTE)) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                o_in_ready = 1'b1;
                o_busy     = 1'b1;
                if (w_accept && (r_byte_cnt == 4'd15)) begin
`ifdef LOADER_CSUM_EN
                    w_state_nxt = S_CSUM;
`else
                    w_state_nxt = S_COMMIT;
`endif
                end else if (w_timeout) begin
                    w_state_nxt = S_ABORT;
                end
            end
`ifdef LOADER_CSUM_EN
            S_CSUM: begin
                o_in_ready = 1'b1;
                o_busy     = 1'b1;
                if (w_accept) w_state_nxt = (w_csum_total == 8'd0) ? S_COMMIT : S_ABORT;
                else if (w_timeout) w_state_nxt = S_ABORT;
            end
`endif
            S_COMMIT: begin
                o_done      = 1'b1;
                w_state_nxt = S_HOLD;
            end
            S_ABORT: begin
                o_err       = 1'b1;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (r_hold_cnt <= HOLD_W'(1)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_HOLD;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= HOLD_W'(HOLD_CYCLES);
            r_gap      <= '0;
            r_byte_cnt <= '0;
            r_mem_bus  <= RESET_IMAGE;
        end else begin
            r_state <= w_state_nxt;
            if (w_in_frame && !w_accept) r_gap <= r_gap + GAP_W'(1);
            else r_gap <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && (i_in_data == SYNC_BYTE)) r_byte_cnt <= '0;
                end
                S_LOAD: begin
                    if (w_accept) r_byte_cnt <= r_byte_cnt + 4'd1;
                end
                S_COMMIT: begin
                    r_mem_bus  <= r_stage;
                    r_hold_cnt <= HOLD_W'(HOLD_CYCLES);
                end
                S_ABORT: begin
                    r_byte_cnt <= '0;
                    r_hold_cnt <= HOLD_W'(HOLD_CYCLES);
                end
                S_HOLD: begin
                    if (r_hold_cnt != '0) r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Staging buffer and running sum carry no reset; every frame rewrites them before use.
    always_ff @(posedge i_clk) begin
        if ((r_state == S_LOAD) && w_accept) r_stage[r_byte_cnt] <= i_in_data;
`ifdef LOADER_CSUM_EN
        if (r_state == S_IDLE) r_sum <= '0;
        else if ((r_state == S_LOAD) && w_accept) r_sum <= r_sum + i_in_data;
`endif
    end

endmodule

// File: tb/tb_td4_prog_loader.sv
// Bench for td4_prog_loader: directed scenarios plus randomized frames against a frame-level model.
module tb_td4_prog_loader;
    localparam int           HOLD = 4;
    localparam int           TMO  = 8;
    localparam logic [7:0]   SYNC = 8'hA5;
    localparam logic [127:0] RI   = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_in_valid = 1'b0;
    logic [7:0]   i_in_data = 8'h00;
    logic         o_in_ready;
    logic [127:0] o_mem_bus;
    logic         o_cpu_rst_n;
    logic         o_busy;
    logic         o_done;
    logic         o_err;
    logic [3:0]   o_byte_cnt;

    int checks = 0;
    int failures = 0;
    int exp_done = 0;
    int exp_err = 0;
    logic [127:0] model_img;
    logic [7:0]   fd [16];

    int n_done = 0;
    int n_err = 0;
    int hold_run = 0;
    int last_hold = -1;
    bit after_pulse = 1'b0;
    bit both_seen = 1'b0;

    td4_prog_loader #(
        .SYNC_BYTE(SYNC), .HOLD_CYCLES(HOLD), .TIMEOUT_CYC(TMO), .RESET_IMAGE(RI)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .i_in_data(i_in_data),
        .o_in_ready(o_in_ready), .o_mem_bus(o_mem_bus), .o_cpu_rst_n(o_cpu_rst_n),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_byte_cnt(o_byte_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Pulse counters and core-reset low time following each DONE/ERR pulse.
    always @(negedge i_clk) begin
        if (o_done && o_err) both_seen <= 1'b1;
        if (o_done) n_done <= n_done + 1;
        if (o_err) n_err <= n_err + 1;
        if (o_done || o_err) begin
            after_pulse <= 1'b1;
            hold_run    <= 0;
        end else if (after_pulse) begin
            if (!o_cpu_rst_n) hold_run <= hold_run + 1;
            else begin
                last_hold   <= hold_run;
                after_pulse <= 1'b0;
            end
        end
    end

    function automatic logic [7:0] frame_sum();
        int s = 0;
        for (int i = 0; i < 16; i++) s += fd[i];
        return 8'(s % 256);
    endfunction

    function automatic logic [127:0] frame_img();
        logic [127:0] img;
        for (int i = 0; i < 16; i++) img[8*i +: 8] = fd[i];
        return img;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        i_in_valid = 1'b0;
        repeat (gap) begin @(posedge i_clk); #1; end
        i_in_valid = 1'b1;
        i_in_data  = b;
        w = 0;
        while (!o_in_ready && w < 64) begin @(posedge i_clk); #1; w++; end
        if (w >= 64) begin
            checks++; failures++;
            $display("FAIL send_ready: IN_READY stayed 0 for %0d cycles, required 1", w);
        end
        @(posedge i_clk); #1;
        i_in_valid = 1'b0;
    endtask

    task automatic send_frame(input int gap_max, input logic [7:0] csum);
        send_byte(SYNC, 0);
        for (int i = 0; i < 16; i++) send_byte(fd[i], $urandom_range(gap_max, 0));
`ifdef LOADER_CSUM_EN
        send_byte(csum, $urandom_range(gap_max, 0));
`endif
    endtask

    task automatic wait_pulse(output int n);
        n = 0;
        while (!(o_done || o_err) && n < 40) begin @(posedge i_clk); #1; n++; end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (!o_cpu_rst_n && n < 40) begin @(posedge i_clk); #1; n++; end
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset();
        int n;
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        checks++; if (o_mem_bus !== RI) begin failures++; $display("FAIL rst_mem: got %h expected %h", o_mem_bus, RI); end
        checks++; if (o_cpu_rst_n !== 1'b0) begin failures++; $display("FAIL rst_cpu_rst_n: got %b expected 0", o_cpu_rst_n); end
        checks++; if (o_in_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b expected 0", o_in_ready); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b expected 0", o_done); end
        checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b expected 0", o_err); end
        checks++; if (o_byte_cnt !== 4'd0) begin failures++; $display("FAIL rst_byte_cnt: got %0d expected 0", o_byte_cnt); end
        i_rst = 1'b0;
        n = 0;
        do begin @(posedge i_clk); #1; n++; end while (!o_cpu_rst_n && n < 20);
        checks++; if (n != HOLD) begin failures++; $display("FAIL rst_hold_len: got %0d cycles expected %0d", n, HOLD); end
        checks++; if (o_in_ready !== 1'b1) begin failures++; $display("FAIL idle_ready: got %b expected 1", o_in_ready); end
        checks++; if (o_mem_bus !== RI) begin failures++; $display("FAIL idle_mem: got %h expected %h", o_mem_bus, RI); end
        model_img = RI;
    endtask

    task automatic test_back_to_back();
        int n;
        for (int i = 0; i < 16; i++) fd[i] = 8'(i);
        send_byte(SYNC, 0);
        checks++; if (o_cpu_rst_n !== 1'b0) begin failures++; $display("FAIL load_cpu_rst_n: got %b expected 0", o_cpu_rst_n); end
        checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL load_busy: got %b expected 1", o_busy); end
        checks++; if (o_byte_cnt !== 4'd0) begin failures++; $display("FAIL load_cnt0: got %0d expected 0", o_byte_cnt); end
        for (int i = 0; i < 16; i++) begin
            send_byte(fd[i], 0);
            if (i == 8) begin
                checks++; if (o_byte_cnt !== 4'd9) begin failures++; $display("FAIL load_cnt9: got %0d expected 9", o_byte_cnt); end
            end
        end
`ifdef LOADER_CSUM_EN
        send_byte(8'(9'h100 - frame_sum()), 0);
`endif
        checks++; if (o_done !== 1'b1) begin failures++; $display("FAIL b2b_done: got %b expected 1", o_done); end
        checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL b2b_err: got %b expected 0", o_err); end
        exp_done++;
        model_img = frame_img();
        @(posedge i_clk); #1;
        checks++; if (o_mem_bus !== model_img) begin failures++; $display("FAIL b2b_mem: got %h expected %h", o_mem_bus, model_img); end
        checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL b2b_done_width: got %b expected 0", o_done); end
        checks++; if (o_byte_cnt !== 4'd0) begin failures++; $display("FAIL b2b_cnt_wrap: got %0d expected 0", o_byte_cnt); end
        wait_idle(n);
        checks++; if (last_hold != HOLD) begin failures++; $display("FAIL b2b_hold: got %0d expected %0d", last_hold, HOLD); end
    endtask

    task automatic test_csum_err();
`ifdef LOADER_CSUM_EN
        int n;
        for (int i = 0; i < 16; i++) fd[i] = 8'(i);
        send_frame(0, 8'(9'h101 - frame_sum()));
        checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL csum_err: got %b expected 1", o_err); end
        checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL csum_done: got %b expected 0", o_done); end
        exp_err++;
        @(posedge i_clk); #1;
        checks++; if (o_mem_bus !== model_img) begin failures++; $display("FAIL csum_mem: got %h expected %h", o_mem_bus, model_img); end
        wait_idle(n);
        checks++; if (o_cpu_rst_n !== 1'b1) begin failures++; $display("FAIL csum_release: got %b expected 1", o_cpu_rst_n); end
        checks++; if (last_hold != HOLD) begin failures++; $display("FAIL csum_hold: got %0d expected %0d", last_hold, HOLD); end
`endif
    endtask

    task automatic test_sync_hunt();
        int n;
        send_byte(8'h11, 0);
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL hunt_busy: got %b expected 0", o_busy); end
        checks++; if (o_cpu_rst_n !== 1'b1) begin failures++; $display("FAIL hunt_cpu: got %b expected 1", o_cpu_rst_n); end
        send_byte(8'h22, 0);
        for (int i = 0; i < 16; i++) fd[i] = SYNC;
        send_frame(0, 8'(9'h100 - frame_sum()));
        checks++; if (o_done !== 1'b1) begin failures++; $display("FAIL hunt_done: got %b expected 1", o_done); end
        exp_done++;
        model_img = frame_img();
        @(posedge i_clk); #1;
        checks++; if (o_mem_bus !== model_img) begin failures++; $display("FAIL hunt_mem: got %h expected %h", o_mem_bus, model_img); end
        wait_idle(n);
    endtask

    task automatic test_timeout();
        int n;
        send_byte(SYNC, 0);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0);
        checks++; if (o_byte_cnt !== 4'd5) begin failures++; $display("FAIL tmo_cnt: got %0d expected 5", o_byte_cnt); end
        n = 0;
        while (!o_err && n < 30) begin @(posedge i_clk); #1; n++; end
        checks++; if (n != TMO) begin failures++; $display("FAIL tmo_latency: got %0d idle cycles expected %0d", n, TMO); end
        checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL tmo_done: got %b expected 0", o_done); end
        exp_err++;
        @(posedge i_clk); #1;
        checks++; if (o_mem_bus !== model_img) begin failures++; $display("FAIL tmo_mem: got %h expected %h", o_mem_bus, model_img); end
        wait_idle(n);
        checks++; if (last_hold != HOLD) begin failures++; $display("FAIL tmo_hold: got %0d expected %0d", last_hold, HOLD); end
        for (int i = 0; i < 16; i++) fd[i] = 8'($urandom);
        send_frame(2, 8'(9'h100 - frame_sum()));
        wait_pulse(n);
        checks++; if (o_done !== 1'b1) begin failures++; $display("FAIL tmo_recover_done: got %b expected 1", o_done); end
        exp_done++;
        model_img = frame_img();
        @(posedge i_clk); #1;
        checks++; if (o_mem_bus !== model_img) begin failures++; $display("FAIL tmo_recover_mem: got %h expected %h", o_mem_bus, model_img); end
        wait_idle(n);
    endtask

    task automatic test_reset_midframe();
        int n;
        send_byte(SYNC, 0);
        for (int i = 0; i < 9; i++) send_byte(8'($urandom), 0);
        checks++; if (o_byte_cnt !== 4'd9) begin failures++; $display("FAIL mid_cnt: got %0d expected 9", o_byte_cnt); end
        #2 i_rst = 1'b1;
        #1;
        checks++; if (o_mem_bus !== RI) begin failures++; $display("FAIL mid_mem: got %h expected %h", o_mem_bus, RI); end
        checks++; if (o_byte_cnt !== 4'd0) begin failures++; $display("FAIL mid_cnt_rst: got %0d expected 0", o_byte_cnt); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b expected 0", o_busy); end
        checks++; if (o_cpu_rst_n !== 1'b0) begin failures++; $display("FAIL mid_cpu: got %b expected 0", o_cpu_rst_n); end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        model_img = RI;
        wait_idle(n);
        checks++; if (n != HOLD) begin failures++; $display("FAIL mid_hold_len: got %0d expected %0d", n, HOLD); end
        for (int i = 0; i < 16; i++) fd[i] = 8'($urandom);
        send_frame(1, 8'(9'h100 - frame_sum()));
        wait_pulse(n);
        checks++; if (o_done !== 1'b1) begin failures++; $display("FAIL mid_recover_done: got %b expected 1", o_done); end
        exp_done++;
        model_img = frame_img();
        @(posedge i_clk); #1;
        checks++; if (o_mem_bus !== model_img) begin failures++; $display("FAIL mid_recover_mem: got %h expected %h", o_mem_bus, model_img); end
        wait_idle(n);
    endtask

    task automatic test_random();
        int n;
        bit good;
        logic [7:0] csum;
        logic [7:0] junk;
        for (int f = 0; f < 24; f++) begin
            for (int j = $urandom_range(2, 0); j > 0; j--) begin
                junk = 8'($urandom);
                if (junk == SYNC) junk = 8'h5A;
                send_byte(junk, $urandom_range(2, 0));
            end
            for (int i = 0; i < 16; i++) fd[i] = 8'($urandom);
            csum = 8'(9'h100 - frame_sum());
            good = 1'b1;
`ifdef LOADER_CSUM_EN
            if ($urandom_range(3, 0) == 0) begin
                csum = csum + 8'($urandom_range(255, 1));
                good = 1'b0;
            end
`endif
            send_frame(3, csum);
            wait_pulse(n);
            checks++; if (o_done !== good) begin failures++; $display("FAIL rnd_done[%0d]: got %b expected %b", f, o_done, good); end
            checks++; if (o_err !== !good) begin failures++; $display("FAIL rnd_err[%0d]: got %b expected %b", f, o_err, !good); end
            if (good) begin exp_done++; model_img = frame_img(); end
            else exp_err++;
            @(posedge i_clk); #1;
            checks++; if (o_mem_bus !== model_img) begin failures++; $display("FAIL rnd_mem[%0d]: got %h expected %h", f, o_mem_bus, model_img); end
            wait_idle(n);
            checks++; if (last_hold != HOLD) begin failures++; $display("FAIL rnd_hold[%0d]: got %0d expected %0d", f, last_hold, HOLD); end
        end
    endtask

    task automatic test_pulse_totals();
        checks++; if (both_seen !== 1'b0) begin failures++; $display("FAIL done_err_overlap: got %b expected 0", both_seen); end
        checks++; if (n_done != exp_done) begin failures++; $display("FAIL done_count: got %0d expected %0d", n_done, exp_done); end
        checks++; if (n_err != exp_err) begin failures++; $display("FAIL err_count: got %0d expected %0d", n_err, exp_err); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_csum_err();
        test_sync_hunt();
        test_timeout();
        test_reset_midframe();
        test_random();
        test_pulse_totals();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
